mem_arbiter: RTL

Two-thread memory port arbiter for the dual-PC pipelined stack processor. Thread 0 and thread 1 each present fetch, load and store requests. The block grants at most one of them per cycle onto a single-ported 16-bit word memory, using round-robin priority, and routes read data back to the granted thread one cycle later. It sits between the processor's per-thread fetch/load/store stages and the main memory array.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-thread memory port arbiter:
// word widths, lock state encoding and thread identifiers.
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } lock_state_t;

  localparam logic THREAD0 = 1'b0;
  localparam logic THREAD1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin picker: one-hot grant plus the pointer to use next.
// Purely combinational so it can be reused by other two-port arbiters.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_next
);

  always_comb begin
    gnt[0] = req[0] & (~req[1] | (ptr == THREAD0));
    gnt[1] = req[1] & (~req[0] | (ptr == THREAD1));
    // The pointer always moves away from whoever was just granted.
    if (gnt[0]) begin
      ptr_next = THREAD1;
    end else if (gnt[1]) begin
      ptr_next = THREAD0;
    end else begin
      ptr_next = ptr;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-thread round-robin arbiter onto a single-ported word memory.
// Define MEM_ARB_LOCK_EN to add lock0/lock1 and the bounded lock state machine.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
`ifdef MEM_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  input  logic          hold,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          idle,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    lock_state
);

  logic        ptr;
  logic        ptr_next;
  logic        rd_pend;
  logic        rd_tag;
  logic        hold_q;
  logic        active;
  logic [1:0]  req_eff;
  logic [1:0]  gnt;
  lock_state_t lock_q;

  // Grants are suppressed while in reset so the memory strobes read as zero.
  assign active     = reset & ~hold;
  assign req_eff[0] = req0 & active & (lock_q != OWN1);
  assign req_eff[1] = req1 & active & (lock_q != OWN0);

  rr_pick u_pick (
    .req      (req_eff),
    .ptr      (ptr),
    .gnt      (gnt),
    .ptr_next (ptr_next)
  );

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign mem_en    = |gnt;
  assign mem_we    = gnt[0] ? we0 : (gnt[1] ? we1 : 1'b0);
  assign mem_addr  = gnt[0] ? addr0 : (gnt[1] ? addr1 : '0);
  assign mem_wdata = gnt[0] ? wdata0 : (gnt[1] ? wdata1 : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= THREAD0;
      rd_pend <= 1'b0;
      rd_tag  <= THREAD0;
      hold_q  <= 1'b0;
    end else begin
      ptr     <= ptr_next;
      rd_pend <= mem_en & ~mem_we;
      rd_tag  <= gnt[1] ? THREAD1 : THREAD0;
      hold_q  <= hold;
    end
  end

  assign rvalid0    = rd_pend & (rd_tag == THREAD0);
  assign rvalid1    = rd_pend & (rd_tag == THREAD1);
  assign rdata      = rd_pend ? mem_rdata : '0;
  // Hold must have been seen for a full cycle and the last read returned.
  assign idle       = hold_q & ~rd_pend;
  assign lock_state = lock_q;

`ifdef MEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  lock_state_t lock_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (lock_q == UNLOCKED) ? CW'(1) : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= UNLOCKED;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    lock_d = lock_q;
    cnt_d  = cnt_q;
    if (active) begin
      unique case (lock_q)
        UNLOCKED: begin
          if ((gnt[0] && lock0) || (gnt[1] && lock1)) begin
            lock_d = gnt[0] ? OWN0 : OWN1;
            cnt_d  = cnt_inc;
            if (cnt_inc == CW'(LOCK_MAX)) begin
              lock_d = UNLOCKED;
              cnt_d  = '0;
            end
          end
        end
        OWN0: begin
          if (!req0 || (gnt[0] && (!lock0 || cnt_inc == CW'(LOCK_MAX)))) begin
            lock_d = UNLOCKED;
            cnt_d  = '0;
          end else if (gnt[0]) begin
            cnt_d = cnt_inc;
          end
        end
        OWN1: begin
          if (!req1 || (gnt[1] && (!lock1 || cnt_inc == CW'(LOCK_MAX)))) begin
            lock_d = UNLOCKED;
            cnt_d  = '0;
          end else if (gnt[1]) begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          lock_d = UNLOCKED;
          cnt_d  = '0;
        end
      endcase
    end
  end
`else
  assign lock_q = UNLOCKED;
`endif

endmodule
